// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command byte transmitter driving open-drain clock/data enables
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int SETUP_CYCLES   = 200,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic       TX_DONE,
    output logic       TX_ERR,
    output logic       BUSY,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int SW = $clog2(SETUP_CYCLES + 1);
    localparam int CW = IW > SW ? IW : SW;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE, DONE, ERR} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WW-1:0] wd, wd_n;
    logic [3:0]    idx, idx_n;
    logic [7:0]    sh, sh_n;
    logic          par, par_n, dbit, dbit_n;
    logic [1:0]    clk_s, dat_s;
    logic          clk_prev, fall, timeout;

    assign fall    = clk_prev & ~clk_s[1];
    assign timeout = wd == WW'(TIMEOUT_CYCLES - 1);

    // two-stage synchronizers for both lines plus clock history for fall detection
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            clk_s    <= 2'b11;
            dat_s    <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_s    <= {clk_s[0], PS2_CLK_IN};
            dat_s    <= {dat_s[0], PS2_DATA_IN};
            clk_prev <= clk_s[1];
        end
    end

    // state, phase timers, watchdog and frame shift register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            cnt   <= '0;
            wd    <= '0;
            idx   <= '0;
            sh    <= '0;
            par   <= 1'b0;
            dbit  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            wd    <= wd_n;
            idx   <= idx_n;
            sh    <= sh_n;
            par   <= par_n;
            dbit  <= dbit_n;
        end
    end

    // next-state: timed inhibit/setup, bit shifting on device clock falls, ack check, watchdog abort
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        wd_n    = wd;
        idx_n   = idx;
        sh_n    = sh;
        par_n   = par;
        dbit_n  = dbit;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (TX_VALID) begin
                    state_n = INHIBIT;
                    sh_n    = TX_DATA;
                    par_n   = ~^TX_DATA;
                end
            end
            INHIBIT: begin
                state_n = cnt == CW'(INHIBIT_CYCLES - 1) ? RTS : INHIBIT;
                cnt_n   = cnt == CW'(INHIBIT_CYCLES - 1) ? '0 : cnt + CW'(1);
            end
            RTS: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CW'(SETUP_CYCLES - 1)) begin
                    state_n = SEND;
                    cnt_n   = '0;
                    idx_n   = '0;
                    dbit_n  = 1'b1;
                    wd_n    = '0;
                end
            end
            SEND, ACK, WAIT_IDLE: begin
                wd_n = wd == WW'(TIMEOUT_CYCLES) ? wd : wd + WW'(1);
                if (timeout) begin
                    state_n = ERR;
                    dbit_n  = 1'b0;
                end else if (state == SEND) begin
                    if (fall) begin
                        idx_n   = idx + 4'd1;
                        dbit_n  = idx < 4'd8 ? ~sh[0] : idx == 4'd8 ? ~par : 1'b0;
                        sh_n    = idx < 4'd8 ? {1'b0, sh[7:1]} : sh;
                        state_n = idx == 4'd9 ? ACK : SEND;
                    end
                end else if (state == ACK) begin
                    if (fall) state_n = dat_s[1] ? ERR : WAIT_IDLE;
                end else if (clk_s[1] & dat_s[1]) begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign TX_READY    = state == IDLE;
    assign BUSY        = state != IDLE;
    assign TX_DONE     = state == DONE;
    assign TX_ERR      = state == ERR;
    assign PS2_CLK_OE  = state == INHIBIT || state == RTS;
    assign PS2_DATA_OE = state == RTS || (state == SEND && dbit);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model with scoreboard checking host transmit frames
module tb_ps2_host_tx;
    localparam int INH = 40, SET = 8, TO = 1000;
    localparam int OK = 0, NACK = 1, SILENT = 2, RSTM = 3;

    typedef struct {
        logic [7:0] data;
        int         mode;
        logic       par;
        logic       done;
        logic       err;
    } vec_t;

    logic       CLK = 1'b0, RST_N = 1'b0, TX_VALID = 1'b0;
    logic [7:0] TX_DATA = 8'h00;
    logic       TX_READY, TX_DONE, TX_ERR, BUSY, PS2_CLK_OE, PS2_DATA_OE;
    logic       dev_clk = 1'b1, dev_dat = 1'b1;
    logic       clk_line, dat_line;
    vec_t       vecs[4];
    vec_t       sb[$];
    int         n_chk = 0, n_fail = 0, done_cnt = 0, err_cnt = 0;

    assign clk_line = dev_clk & ~PS2_CLK_OE;
    assign dat_line = dev_dat & ~PS2_DATA_OE;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST_N(RST_N), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
        .TX_READY(TX_READY), .TX_DONE(TX_DONE), .TX_ERR(TX_ERR), .BUSY(BUSY),
        .PS2_CLK_IN(clk_line), .PS2_DATA_IN(dat_line),
        .PS2_CLK_OE(PS2_CLK_OE), .PS2_DATA_OE(PS2_DATA_OE)
    );

    always #5 CLK = ~CLK;

    // pulse counters for completion/error events
    always @(posedge CLK) begin
        if (TX_DONE) done_cnt <= done_cnt + 1;
        if (TX_ERR) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input int mode, input logic p, input logic dn, input logic er);
        vec_t v;
        v.data = d; v.mode = mode; v.par = p; v.done = dn; v.err = er;
        sb.push_back(v);
        TX_DATA = d;
        TX_VALID = 1'b1;
    endtask

    task automatic dev_frame(input logic drop, input logic [7:0] nxt);
        vec_t v;
        int n, d0, e0;
        logic [10:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() == 0) return;
        v = sb.pop_front();
        n = 0;
        while (!PS2_CLK_OE && n < 300) begin @(negedge CLK); n++; end
        chk("inhibit_start", PS2_CLK_OE, 1);
        if (drop) TX_VALID = 1'b0; else TX_DATA = nxt;
        n = 0;
        while (PS2_CLK_OE && !PS2_DATA_OE && n < 5 * INH) begin n++; @(negedge CLK); end
        chk("inhibit_len", n, INH);
        n = 0;
        while (PS2_CLK_OE && PS2_DATA_OE && n < 5 * SET) begin n++; @(negedge CLK); end
        chk("setup_len", n, SET);
        bits = '1;
        bits[0] = dat_line;
        if (v.mode == SILENT) begin
            n = 0;
            while (!TX_ERR && n < 5 * TO) begin n++; @(negedge CLK); end
            chk("timeout_len", n, TO);
            chk("timeout_oe", {PS2_CLK_OE, PS2_DATA_OE}, 0);
        end else begin
            repeat (10) @(negedge CLK);
            for (int k = 1; k <= 10; k++) begin
                dev_clk = 1'b0;
                if (v.mode == RSTM && k == 5) begin
                    repeat (5) @(negedge CLK);
                    RST_N = 1'b0;
                    @(posedge CLK);
                    #1;
                    chk("rst_oe", {PS2_CLK_OE, PS2_DATA_OE}, 0);
                    chk("rst_busy", BUSY, 0);
                    chk("rst_ready", TX_READY, 1);
                    @(negedge CLK);
                    RST_N = 1'b1;
                    dev_clk = 1'b1;
                    repeat (20) @(negedge CLK);
                    chk("rst_no_done", done_cnt - d0, 0);
                    chk("rst_no_err", err_cnt - e0, 0);
                    return;
                end
                repeat (20) @(negedge CLK);
                dev_clk = 1'b1;
                bits[k] = dat_line;
                repeat (20) @(negedge CLK);
            end
            dev_dat = v.mode == NACK;
            repeat (5) @(negedge CLK);
            dev_clk = 1'b0;
            repeat (20) @(negedge CLK);
            dev_clk = 1'b1;
            repeat (5) @(negedge CLK);
            dev_dat = 1'b1;
            chk("frame_bits", bits, {1'b1, v.par, v.data, 1'b0});
        end
        n = 0;
        while (done_cnt + err_cnt == d0 + e0 && n < 200) begin n++; @(negedge CLK); end
        chk("done_pulses", done_cnt - d0, v.done);
        chk("err_pulses", err_cnt - e0, v.err);
        chk("idle_oe", {PS2_CLK_OE, PS2_DATA_OE}, 0);
        chk("idle_ready", TX_READY, 1);
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{8'hED, OK,     1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'hA5, OK,     1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'h07, NACK,   1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h3C, SILENT, 1'b1, 1'b0, 1'b1};
        repeat (3) @(negedge CLK);
        chk("reset_ready", TX_READY, 1);
        chk("reset_busy", BUSY, 0);
        chk("reset_oe", {PS2_CLK_OE, PS2_DATA_OE}, 0);
        chk("reset_pulses", {TX_DONE, TX_ERR}, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, vecs[i].mode, vecs[i].par, vecs[i].done, vecs[i].err);
            dev_frame(1'b1, 8'h00);
        end
        send(8'h01, OK, 1'b0, 1'b1, 1'b0);
        dev_frame(1'b0, 8'h00);
        send(8'h00, OK, 1'b1, 1'b1, 1'b0);
        dev_frame(1'b1, 8'h00);
        send(8'h81, RSTM, 1'b1, 1'b0, 1'b0);
        dev_frame(1'b1, 8'h00);
        send(8'hFF, OK, 1'b1, 1'b1, 1'b0);
        dev_frame(1'b1, 8'h00);
        send(8'hA5, OK, 1'b1, 1'b1, 1'b0);
        fork
            dev_frame(1'b1, 8'h00);
            begin
                repeat (60) @(negedge CLK);
                TX_DATA = 8'h5A;
                TX_VALID = 1'b1;
                repeat (3) @(negedge CLK);
                TX_VALID = 1'b0;
            end
        join
        n = 0;
        repeat (300) begin
            @(negedge CLK);
            if (BUSY) n++;
        end
        chk("no_extra_xfer", n, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
